// File: rtl/uart_rx_if.sv
// Register-port bundle shared by the UART receiver and whatever drives its bus.
// The master drives strobes and write data; the slave returns read data and status.
interface uart_rx_if;
  logic       en;
  logic [1:0] addr;
  logic       re;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rx_valid;
  logic       frame_err;

  modport master (
    output en, addr, re, we, wdata,
    input  rdata, rx_valid, frame_err
  );

  modport slave (
    input  en, addr, re, we, wdata,
    output rdata, rx_valid, frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-bit register port (RXDATA, STATUS, BAUD).
// Holds one received byte plus valid/framing/overrun flags until RXDATA is read.
module uart_rx #(
  parameter logic [7:0] DIV_RST = 8'd130
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.slave   bus,
  input  logic       rx,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [1:0] A_RXDATA = 2'b00;
  localparam logic [1:0] A_STATUS = 2'b01;
  localparam logic [1:0] A_BAUD   = 2'b10;

  logic       rx_meta, rx_s, rx_prev;
  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shift, shift_n;
  logic [7:0] div_q, div_q_n;
  logic [7:0] div;
  logic [7:0] holding;
  logic       rx_valid_q, frame_err_q, overrun_q;

  logic       rd_clr;
  logic       valid_eff;
  logic       load_byte, set_ovr, set_ferr;

  // A read of RXDATA clears flags before this edge's new events are applied.
  assign rd_clr    = bus.re && (bus.addr == A_RXDATA);
  assign valid_eff = rx_valid_q && !rd_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      div_q   <= DIV_RST;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      div_q   <= div_q_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_idx;
    shift_n   = shift;
    div_q_n   = div_q;
    load_byte = 1'b0;
    set_ovr   = 1'b0;
    set_ferr  = 1'b0;
    case (state)
      IDLE: begin
        if ((div >= 8'd2) && rx_prev && !rx_s) begin
          state_n = START;
          cnt_n   = '0;
          div_q_n = div;
        end
      end
      START: begin
        // Half a bit in: a high line here means the edge was a glitch.
        if (cnt == (div_q >> 1) - 8'd1) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            bit_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DATA: begin
        if (cnt == div_q - 8'd1) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      STOP: begin
        if (cnt == div_q - 8'd1) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) begin
            if (valid_eff) set_ovr = 1'b1;
            else           load_byte = 1'b1;
          end else begin
            set_ferr = 1'b1;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Disabling abandons any frame in flight without touching held data.
    if (!bus.en) begin
      state_n   = IDLE;
      cnt_n     = '0;
      load_byte = 1'b0;
      set_ovr   = 1'b0;
      set_ferr  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= DIV_RST;
      holding     <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (bus.we && (bus.addr == A_BAUD)) div <= bus.wdata;
      if (load_byte) holding <= shift;
      rx_valid_q  <= load_byte || valid_eff;
      frame_err_q <= set_ferr || (frame_err_q && !rd_clr);
      overrun_q   <= set_ovr  || (overrun_q   && !rd_clr);
    end
  end

  always_comb begin
    bus.rdata = 8'h00;
    if (bus.re) begin
      case (bus.addr)
        A_RXDATA: bus.rdata = holding;
        A_STATUS: bus.rdata = {5'b0, overrun_q, frame_err_q, rx_valid_q};
        A_BAUD:   bus.rdata = div;
        default:  bus.rdata = 8'h00;
      endcase
    end
  end

  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames in, register reads checked by a
// scoreboard monitor that pops the expected value whenever a read strobe is seen.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [1:0] state_dbg;

  uart_rx_if bus ();

  uart_rx #(.DIV_RST(8'd130)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rx        (rx),
    .state_dbg (state_dbg)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  string       name_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.re) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read: got %h, required no read pending", bus.rdata);
      end else begin
        logic [7:0] e;
        string      nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (bus.rdata !== e) begin
          n_err++;
          $display("FAIL %s: got %h, required %h", nm, bus.rdata, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic reg_read(input string nm, input logic [1:0] a, input logic [7:0] exp);
    @(posedge clk); #1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    bus.addr = a;
    bus.re   = 1'b1;
    @(posedge clk); #1;
    bus.re   = 1'b0;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    @(posedge clk); #1;
    bus.we    = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input int n);
    @(posedge clk); #1;
    rx = b;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int div);
    drive_bit(1'b0, div);
    for (int i = 0; i < 8; i++) drive_bit(d[i], div);
    drive_bit(stop, div);
    if (stop) drive_bit(1'b1, 4);
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!bus.rx_valid && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_rx_valid", {7'b0, bus.rx_valid}, 8'h01);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rx = 1'b1;
    bus.en = 1'b0; bus.addr = 2'b00; bus.re = 1'b0; bus.we = 1'b0; bus.wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_valid",  {7'b0, bus.rx_valid},  8'h00);
    check("reset_frame_err", {7'b0, bus.frame_err}, 8'h00);
    check("reset_rdata",     bus.rdata,             8'h00);
    check("reset_state",     {6'b0, state_dbg},     8'h00);
    rst = 1'b0;
    reg_read("reset_baud",   2'b10, 8'd130);
    reg_read("reset_status", 2'b01, 8'h00);
    bus.en = 1'b1;

    // default divisor frame
    send_frame(8'hAB, 1'b1, 130);
    wait_valid(200);
    reg_read("ab_status_pre", 2'b01, 8'h01);
    reg_read("ab_rxdata",     2'b00, 8'hAB);
    reg_read("ab_status",     2'b01, 8'h00);

    // faster divisor, back-to-back reads
    reg_write(2'b10, 8'd16);
    reg_read("baud16", 2'b10, 8'd16);
    send_frame(8'h55, 1'b1, 16);
    reg_read("rx_55", 2'b00, 8'h55);
    send_frame(8'h00, 1'b1, 16);
    reg_read("rx_00", 2'b00, 8'h00);
    reg_read("status_after_00", 2'b01, 8'h00);
    reg_read("reserved_addr",   2'b11, 8'h00);

    // overrun
    send_frame(8'h3C, 1'b1, 16);
    send_frame(8'hC3, 1'b1, 16);
    reg_read("ovr_status", 2'b01, 8'h05);
    reg_read("ovr_rxdata", 2'b00, 8'h3C);
    reg_read("ovr_cleared", 2'b01, 8'h00);

    // framing error followed by a break
    send_frame(8'h81, 1'b0, 16);
    repeat (12) @(posedge clk);
    #1;
    check("ferr_port", {7'b0, bus.frame_err}, 8'h01);
    reg_read("ferr_status", 2'b01, 8'h02);
    repeat (20 * 16) @(posedge clk);
    reg_read("break_status", 2'b01, 8'h02);
    reg_read("break_rxdata", 2'b00, 8'h3C);
    drive_bit(1'b1, 32);
    send_frame(8'h42, 1'b1, 16);
    reg_read("rx_42", 2'b00, 8'h42);
    reg_read("status_after_42", 2'b01, 8'h00);

    // short glitch on idle line
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 40);
    check("glitch_state", {6'b0, state_dbg}, 8'h00);
    reg_read("glitch_status", 2'b01, 8'h00);

    // enable dropped mid-byte
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(i[0], 16);
    drive_bit(1'b1, 8);
    bus.en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("en_low_state", {6'b0, state_dbg}, 8'h00);
    repeat (12 * 16) @(posedge clk);
    #1;
    bus.en = 1'b1;
    reg_read("en_drop_status", 2'b01, 8'h00);
    send_frame(8'h99, 1'b1, 16);
    reg_read("rx_99", 2'b00, 8'h99);
    reg_read("status_after_99", 2'b01, 8'h00);

    // divisor of 1 keeps receiver idle
    reg_write(2'b10, 8'd1);
    send_frame(8'h66, 1'b1, 16);
    reg_read("div1_status", 2'b01, 8'h00);
    reg_write(2'b10, 8'd16);

    // reset in the middle of a frame with a byte held
    send_frame(8'h77, 1'b1, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 8);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk); #1;
    check("rst_rx_valid",  {7'b0, bus.rx_valid},  8'h00);
    check("rst_frame_err", {7'b0, bus.frame_err}, 8'h00);
    check("rst_state",     {6'b0, state_dbg},     8'h00);
    check("rst_rdata",     bus.rdata,             8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    reg_read("rst_baud",   2'b10, 8'd130);
    reg_read("rst_status", 2'b01, 8'h00);
    reg_read("rst_rxdata", 2'b00, 8'h00);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive half of the UART: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the `rx` line and presents them through the same 2-bit-addressed register port (`en`/`addr`/`re`/`we`/`wdata`) the UART transmitter uses. It sits beside the transmitter on the bus and is typically looped back to its `tx` output in system benches. It holds one received byte plus status flags until software reads it.

## Interface
- `DIV_RST`, 8'd130, reset value of the baud divisor (clocks per bit)
- `clk` input 1, system clock, all logic on rising edge
- `rst` input 1, synchronous, active-high reset
- `en` input 1, receiver enable; low forces FSM to IDLE
- `addr` input 2, register select: 00 RXDATA, 01 STATUS, 10 BAUD, 11 reserved
- `re` input 1, read strobe
- `we` input 1, write strobe
- `wdata` input 8, write data
- `rx` input 1, asynchronous serial line, idle high
- `rdata` output 8, read data, combinational from `addr` while `re`=1, else 8'h00
- `rx_valid` output 1, holding register contains an unread byte
- `frame_err` output 1, sticky framing-error flag

## Operation
- Registers:
  - RXDATA (00): read returns holding byte; `re`=1 at 00 clears `rx_valid`, `frame_err`, `overrun` at the clock edge. Writes ignored.
  - STATUS (01): read {5'b0, overrun, frame_err, rx_valid}; no side effects; writes ignored.
  - BAUD (10): read/write divisor `div`; write occurs when `we`=1 at a clock edge.
  - 11: reads 8'h00, writes ignored. `re` and `we` simultaneously: both act.
- `rx` passes through a 2-FF synchronizer (`rx_s`); a third FF gives `rx_prev` for falling-edge detection. All synchronizer FFs reset to 1.
- FSM states IDLE, START, DATA, STOP; 8-bit cycle counter `cnt`, 3-bit bit index, 8-bit shift register, latched divisor `div_q`.
  - IDLE: if `en`=1, `div`>=2 and `rx_prev`=1, `rx_s`=0 -> START, `cnt`=0, `div_q`=`div`.
  - START: when `cnt`==(`div_q`>>1)-1, sample `rx_s`: 0 -> DATA, `cnt`=0, bit index 0; 1 -> IDLE (glitch rejected, no flags).
  - DATA: when `cnt`==`div_q`-1, shift `rx_s` into MSB (shift right), `cnt`=0; after 8th bit -> STOP.
  - STOP: when `cnt`==`div_q`-1, sample `rx_s`: 1 -> load holding register if `rx_valid`=0, else discard byte and set `overrun`; 0 -> discard byte, set `frame_err`. Both -> IDLE.
- Otherwise `cnt` increments by 1 each cycle in START/DATA/STOP.
- BAUD writes mid-frame do not affect the current frame (`div_q` is latched at start).
- `en` low in any state: next state IDLE, partial byte discarded; holding register and flags retained.
- `div` of 0 or 1: receiver stays in IDLE.

## Timing
- Reset values: `rdata` 8'h00 (combinational, `re` low at reset), `rx_valid` 0, `frame_err` 0, `overrun` 0, holding 8'h00, `div` = `DIV_RST`, FSM IDLE, `cnt` 0.
- Edge detection lags `rx` by 3 cycles; START sample lands at mid-bit; `rx_valid` rises ~(9*`div_q` + `div_q`/2 + 3) cycles after `rx` falls, ±1 cycle.
- Falling-edge requirement: a line held low (break) after a framing error produces no further frames until `rx` returns high.
- Same-edge RXDATA read and new-byte load: clear is applied first, so the new byte is loaded, `rx_valid` stays 1, no overrun.
- Same-edge RXDATA read and error set: the newly set flag survives the clear.
- Reset mid-frame: all state returns to reset values on the next edge.

## Test plan
- Reset, `en`=1, default div 130, drive frame 0xAB at 130 clk/bit -> `rx_valid`=1, RXDATA read returns 8'hAB, STATUS afterwards 8'h00.
- Write BAUD=8'd16, send 0x55 then 0x00 reading each between frames -> reads 8'h55, 8'h00, no flags.
- Send 0x3C, do not read, send 0xC3 -> RXDATA reads 8'h3C, STATUS before read shows 8'h05 (overrun+valid).
- Send frame 0x81 with stop bit low -> `frame_err`=1, `rx_valid`=0; hold `rx` low 20 bit-times -> no new frame; release and send 0x42 -> reads 8'h42.
- 0.3-bit low glitch on idle line -> FSM returns to IDLE, no flags, `rx_valid` stays 0.
- Deassert `en` during data bit 4 of a frame, then reassert and send 0x99 -> only 8'h99 is received; assert `rst` mid-frame -> all outputs 0, BAUD reads 8'd130.
